// File: rtl/vector_instr_queue_if.sv
// vector_instr_queue_if: scalar-side push and scoreboard-side pop signals of the vector instruction queue.
interface vector_instr_queue_if #(
    parameter int DATA_FROM_SCALAR = 96,
    parameter int DEPTH = 4
);
    logic valid_scalar;
    logic [DATA_FROM_SCALAR-1:0] data_scalar;
    logic ready_scalar;
    logic flush;
    logic valid_fifo;
    logic [DATA_FROM_SCALAR-1:0] instruction_to_issue;
    logic pop_data;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    modport master (
        output valid_scalar, data_scalar, flush, pop_data,
        input ready_scalar, valid_fifo, instruction_to_issue, occupancy
    );
    modport slave (
        input valid_scalar, data_scalar, flush, pop_data,
        output ready_scalar, valid_fifo, instruction_to_issue, occupancy
    );
endinterface

// File: rtl/vector_instr_queue.sv
// vector_instr_queue: in-order packet FIFO from scalar core to vector scoreboard.
// Define VQ_BYPASS_EN for a combinational empty-queue bypass.
module vector_instr_queue #(
    parameter int DATA_FROM_SCALAR = 96,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    vector_instr_queue_if.slave vq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic empty, push, pop;
    assign empty = (count == '0);
    assign vq.ready_scalar = (count != FULL);
    assign vq.occupancy = count;
    assign pop = vq.pop_data & ~empty;
`ifdef VQ_BYPASS_EN
    logic bypass;
    assign bypass = empty & vq.valid_scalar;
    assign vq.valid_fifo = ~empty | vq.valid_scalar;
    assign vq.instruction_to_issue = bypass ? vq.data_scalar : mem[rd_ptr];
    // A bypassed packet taken by the scoreboard the same cycle never lands in storage
    assign push = vq.valid_scalar & vq.ready_scalar & ~(bypass & vq.pop_data);
`else
    assign vq.valid_fifo = ~empty;
    assign vq.instruction_to_issue = mem[rd_ptr];
    assign push = vq.valid_scalar & vq.ready_scalar;
`endif
    always_ff @(posedge clk) begin
        if (push && !vq.flush && !rst) mem[wr_ptr] <= vq.data_scalar;
    end
    always_ff @(posedge clk) begin
        if (rst || vq.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_vector_instr_queue.sv
// tb_vector_instr_queue: scoreboard-based bench for vector_instr_queue, covering the VQ_BYPASS_EN build when defined.
module tb_vector_instr_queue;
    localparam int W = 96;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] exp_pkt;
    vector_instr_queue_if #(.DATA_FROM_SCALAR(W), .DEPTH(DEPTH)) vq ();
    vector_instr_queue #(.DATA_FROM_SCALAR(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .vq(vq.slave));
    always #5 clk = ~clk;
    function automatic logic [W-1:0] pkt(input int i);
        return {32'h5700_0000 + 32'(i), 32'(i * 7 + 3), ~32'(i)};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        vq.valid_scalar = 1'b0;
        vq.pop_data = 1'b0;
        vq.flush = 1'b0;
    endtask
    task automatic test_reset();
        checks++; if (vq.valid_fifo !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vq.valid_fifo); end
        checks++; if (vq.ready_scalar !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", vq.ready_scalar); end
        checks++; if (vq.occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", vq.occupancy); end
        vq.pop_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (vq.occupancy !== 3'd0) begin failures++; $display("FAIL empty_pop_occ got=%0d exp=0", vq.occupancy); end
            checks++; if (vq.valid_fifo !== 1'b0) begin failures++; $display("FAIL empty_pop_valid got=%b exp=0", vq.valid_fifo); end
        end
        vq.pop_data = 1'b0;
        tick();
        checks++; if (vq.ready_scalar !== 1'b1) begin failures++; $display("FAIL empty_pop_ready got=%b exp=1", vq.ready_scalar); end
    endtask
    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            vq.valid_scalar = 1'b1;
            vq.data_scalar = pkt(i);
            checks++; if (vq.ready_scalar !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, vq.ready_scalar); end
            sb.push_back(pkt(i));
            tick();
            checks++; if (vq.occupancy !== 3'(i + 1)) begin failures++; $display("FAIL fill_occ[%0d] got=%0d exp=%0d", i, vq.occupancy, i + 1); end
        end
        checks++; if (vq.ready_scalar !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", vq.ready_scalar); end
        checks++; if (vq.valid_fifo !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", vq.valid_fifo); end
        checks++; if (vq.instruction_to_issue !== sb[0]) begin failures++; $display("FAIL full_head got=%h exp=%h", vq.instruction_to_issue, sb[0]); end
        vq.data_scalar = pkt(100);
        tick();
        checks++; if (vq.occupancy !== 3'd4) begin failures++; $display("FAIL full_hold_occ got=%0d exp=4", vq.occupancy); end
        vq.valid_scalar = 1'b0;
    endtask
    task automatic test_full_pop();
        vq.valid_scalar = 1'b1;
        vq.data_scalar = pkt(100);
        vq.pop_data = 1'b1;
        exp_pkt = sb.pop_front();
        checks++; if (vq.instruction_to_issue !== exp_pkt) begin failures++; $display("FAIL fullpop_head got=%h exp=%h", vq.instruction_to_issue, exp_pkt); end
        tick();
        checks++; if (vq.occupancy !== 3'd3) begin failures++; $display("FAIL fullpop_occ got=%0d exp=3", vq.occupancy); end
        checks++; if (vq.ready_scalar !== 1'b1) begin failures++; $display("FAIL fullpop_ready got=%b exp=1", vq.ready_scalar); end
        vq.pop_data = 1'b0;
        sb.push_back(pkt(100));
        tick();
        checks++; if (vq.occupancy !== 3'd4) begin failures++; $display("FAIL late_push_occ got=%0d exp=4", vq.occupancy); end
        vq.valid_scalar = 1'b0;
        vq.pop_data = 1'b1;
        while (sb.size() > 0) begin
            exp_pkt = sb.pop_front();
            checks++; if (vq.valid_fifo !== 1'b1 || vq.instruction_to_issue !== exp_pkt) begin failures++; $display("FAIL drain_head got=%b/%h exp=1/%h", vq.valid_fifo, vq.instruction_to_issue, exp_pkt); end
            tick();
        end
        vq.pop_data = 1'b0;
        checks++; if (vq.valid_fifo !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", vq.valid_fifo); end
    endtask
    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            vq.valid_scalar = 1'b1;
            vq.data_scalar = pkt(200 + i);
            sb.push_back(pkt(200 + i));
            tick();
        end
        vq.pop_data = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vq.data_scalar = pkt(210 + i);
            sb.push_back(pkt(210 + i));
            exp_pkt = sb.pop_front();
            checks++; if (vq.instruction_to_issue !== exp_pkt) begin failures++; $display("FAIL stream_head[%0d] got=%h exp=%h", i, vq.instruction_to_issue, exp_pkt); end
            tick();
            checks++; if (vq.occupancy !== 3'd2) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=2", i, vq.occupancy); end
        end
        vq.valid_scalar = 1'b0;
        while (sb.size() > 0) begin
            exp_pkt = sb.pop_front();
            checks++; if (vq.instruction_to_issue !== exp_pkt) begin failures++; $display("FAIL stream_drain got=%h exp=%h", vq.instruction_to_issue, exp_pkt); end
            tick();
        end
        vq.pop_data = 1'b0;
        checks++; if (vq.occupancy !== 3'd0) begin failures++; $display("FAIL stream_end_occ got=%0d exp=0", vq.occupancy); end
    endtask
    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            vq.valid_scalar = 1'b1;
            vq.data_scalar = pkt(300 + i);
            tick();
        end
        checks++; if (vq.occupancy !== 3'd3) begin failures++; $display("FAIL preflush_occ got=%0d exp=3", vq.occupancy); end
        vq.data_scalar = pkt(399);
        vq.flush = 1'b1;
        tick();
        idle();
        checks++; if (vq.occupancy !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", vq.occupancy); end
        checks++; if (vq.valid_fifo !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", vq.valid_fifo); end
        checks++; if (vq.ready_scalar !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", vq.ready_scalar); end
        vq.valid_scalar = 1'b1;
        vq.data_scalar = pkt(310);
        tick();
        vq.valid_scalar = 1'b0;
        checks++; if (vq.occupancy !== 3'd1 || vq.instruction_to_issue !== pkt(310)) begin failures++; $display("FAIL postflush_head got=%0d/%h exp=1/%h", vq.occupancy, vq.instruction_to_issue, pkt(310)); end
        vq.pop_data = 1'b1;
        tick();
        vq.pop_data = 1'b0;
        checks++; if (vq.occupancy !== 3'd0) begin failures++; $display("FAIL postflush_drain got=%0d exp=0", vq.occupancy); end
    endtask
    task automatic test_bypass();
        exp_pkt = {{(W-8){1'b0}}, 8'h57};
        vq.valid_scalar = 1'b1;
        vq.data_scalar = exp_pkt;
`ifdef VQ_BYPASS_EN
        vq.pop_data = 1'b1;
        #1;
        checks++; if (vq.valid_fifo !== 1'b1 || vq.instruction_to_issue !== exp_pkt) begin failures++; $display("FAIL bypass_same got=%b/%h exp=1/%h", vq.valid_fifo, vq.instruction_to_issue, exp_pkt); end
        tick();
        idle();
        #1;
        checks++; if (vq.occupancy !== 3'd0 || vq.valid_fifo !== 1'b0) begin failures++; $display("FAIL bypass_consumed got=%0d/%b exp=0/0", vq.occupancy, vq.valid_fifo); end
        vq.valid_scalar = 1'b1;
`else
        #1;
        checks++; if (vq.valid_fifo !== 1'b0) begin failures++; $display("FAIL nobypass_same got=%b exp=0", vq.valid_fifo); end
`endif
        tick();
        idle();
        checks++; if (vq.occupancy !== 3'd1 || vq.instruction_to_issue !== exp_pkt) begin failures++; $display("FAIL bypass_stored got=%0d/%h exp=1/%h", vq.occupancy, vq.instruction_to_issue, exp_pkt); end
        vq.pop_data = 1'b1;
        tick();
        vq.pop_data = 1'b0;
        checks++; if (vq.occupancy !== 3'd0) begin failures++; $display("FAIL bypass_drain got=%0d exp=0", vq.occupancy); end
    endtask
    initial begin
        idle();
        vq.data_scalar = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_fill();
        test_full_pop();
        test_back_to_back();
        test_flush();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
